// File: rtl/mvm_pkg.sv
// Shared MVM geometry and arbiter FSM encoding.
package mvm_pkg;
  localparam int unsigned R   = 8;
  localparam int unsigned C   = 8;
  localparam int unsigned W_X = 4;
  localparam int unsigned W_K = 3;

  localparam int unsigned W_Y      = W_X + W_K + $clog2(C);
  localparam int unsigned W_BUS_KX = R * C * W_K + C * W_X;
  localparam int unsigned W_BUS_Y  = R * W_Y;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/mvm_tag_fifo.sv
// Requester-tag FIFO: records who issued each outstanding MVM request so responses route back in order.
module mvm_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W_TAG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W_TAG-1:0] tag_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [W_TAG-1:0] head_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W_TAG-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= tag_i;
  end
endmodule

// File: rtl/mvm_rr_arbiter.sv
// Round-robin arbiter sharing one axis_matvec_mul among N_REQ requesters, with in-order response routing.
module mvm_rr_arbiter #(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned W_BUS_KX = mvm_pkg::W_BUS_KX,
  parameter int unsigned W_BUS_Y  = mvm_pkg::W_BUS_Y,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          s_axis_kx_tvalid,
  output logic [N_REQ-1:0]          s_axis_kx_tready,
  input  logic [N_REQ*W_BUS_KX-1:0] s_axis_kx_tdata,
  output logic                      m_axis_kx_tvalid,
  input  logic                      m_axis_kx_tready,
  output logic [W_BUS_KX-1:0]       m_axis_kx_tdata,
  input  logic                      s_axis_y_tvalid,
  output logic                      s_axis_y_tready,
  input  logic [W_BUS_Y-1:0]        s_axis_y_tdata,
  output logic [N_REQ-1:0]          m_axis_y_tvalid,
  input  logic [N_REQ-1:0]          m_axis_y_tready,
  output logic [W_BUS_Y-1:0]        m_axis_y_tdata
);
  import mvm_pkg::state_e;
  import mvm_pkg::IDLE;
  import mvm_pkg::GRANT;

  localparam int unsigned W_TAG = $clog2(N_REQ);

  state_e           state_q, state_d;
  logic [W_TAG-1:0] grant_q, grant_d;
  logic [W_TAG-1:0] rr_ptr_q, rr_ptr_d;
  logic [W_TAG-1:0] pick;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [W_TAG-1:0] fifo_head;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ (N_REQ need not be a power of 2).
  always_comb begin
    int unsigned idx;
    logic        found;
    pick  = rr_ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && s_axis_kx_tvalid[W_TAG'(idx)]) begin
        pick  = W_TAG'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_ptr_d         = rr_ptr_q;
    fifo_push        = 1'b0;
    s_axis_kx_tready = '0;
    m_axis_kx_tvalid = 1'b0;
    m_axis_kx_tdata  = s_axis_kx_tdata[grant_q*W_BUS_KX +: W_BUS_KX];
    if (!rst) begin
      case (state_q)
        IDLE: begin
          // Full check here is the only push gate: each GRANT visit pushes at most once.
          if ((|s_axis_kx_tvalid) && !fifo_full) begin
            grant_d = pick;
            state_d = GRANT;
          end
        end
        GRANT: begin
          m_axis_kx_tvalid          = s_axis_kx_tvalid[grant_q];
          s_axis_kx_tready[grant_q] = m_axis_kx_tready;
          if (m_axis_kx_tvalid && m_axis_kx_tready) begin
            fifo_push = 1'b1;
            rr_ptr_d  = (grant_q == W_TAG'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    s_axis_y_tready = 1'b0;
    m_axis_y_tvalid = '0;
    if (!rst && !fifo_empty) begin
      m_axis_y_tvalid[fifo_head] = s_axis_y_tvalid;
      s_axis_y_tready            = m_axis_y_tready[fifo_head];
    end
  end

  assign m_axis_y_tdata = s_axis_y_tdata;
  assign fifo_pop       = s_axis_y_tvalid & s_axis_y_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  mvm_tag_fifo #(
    .DEPTH (DEPTH),
    .W_TAG (W_TAG)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .tag_i   (grant_q),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );
endmodule

// File: tb/tb_mvm_rr_arbiter.sv
// Directed bench for mvm_rr_arbiter: arbitration table plus multi-cycle corner sequences.
module tb_mvm_rr_arbiter;
  localparam int unsigned NR   = 4;
  localparam int unsigned W_KX = 224;
  localparam int unsigned W_Y  = 80;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   s_kx_tvalid, s_kx_tready;
  logic [NR*W_KX-1:0] s_kx_tdata;
  logic            m_kx_tvalid, m_kx_tready;
  logic [W_KX-1:0] m_kx_tdata;
  logic            s_y_tvalid, s_y_tready;
  logic [W_Y-1:0]  s_y_tdata, m_y_tdata;
  logic [NR-1:0]   m_y_tvalid, m_y_tready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mvm_rr_arbiter #(
    .N_REQ    (NR),
    .W_BUS_KX (W_KX),
    .W_BUS_Y  (W_Y),
    .DEPTH    (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_kx_tvalid (s_kx_tvalid),
    .s_axis_kx_tready (s_kx_tready),
    .s_axis_kx_tdata  (s_kx_tdata),
    .m_axis_kx_tvalid (m_kx_tvalid),
    .m_axis_kx_tready (m_kx_tready),
    .m_axis_kx_tdata  (m_kx_tdata),
    .s_axis_y_tvalid  (s_y_tvalid),
    .s_axis_y_tready  (s_y_tready),
    .s_axis_y_tdata   (s_y_tdata),
    .m_axis_y_tvalid  (m_y_tvalid),
    .m_axis_y_tready  (m_y_tready),
    .m_axis_y_tdata   (m_y_tdata)
  );

  typedef struct {
    logic [NR-1:0] mask;
    int            exp_grant;
  } vec_t;

  function automatic logic [W_KX-1:0] kx_word(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(i);
    return {7{w}};
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_kx_tvalid = '0;
    m_kx_tready = 1'b0;
    s_y_tvalid = 1'b0;
    m_y_tready = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits for a request handshake; cyc is the negedge index (0-based) at which it was seen.
  task automatic wait_kx(output int cyc, output logic [NR-1:0] rdy, output logic [W_KX-1:0] data);
    bit ok;
    ok = 0; cyc = -1; rdy = '0; data = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_kx_tvalid && m_kx_tready) begin
        rdy = s_kx_tready;
        data = m_kx_tdata;
        cyc = i;
        ok = 1;
        @(posedge clk);
        #1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL kx_handshake_timeout: got none expected handshake within 20 cycles");
    end
  endtask

  task automatic respond(input int exp_idx, input string name);
    logic [W_Y-1:0] yd;
    yd = {$urandom(), $urandom(), $urandom()};
    s_y_tdata = yd;
    s_y_tvalid = 1'b1;
    m_y_tready = '1;
    @(negedge clk);
    check({name, "_tvalid"}, m_y_tvalid, onehot(exp_idx));
    check({name, "_tready"}, s_y_tready, 1'b1);
    check({name, "_tdata"}, m_y_tdata, yd);
    @(posedge clk);
    #1 s_y_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int cyc;
    logic [NR-1:0] rdy;
    logic [W_KX-1:0] data;

    // rr_ptr evolves 0 ->1 ->1 ->2 ->0 ->2 ->3 ->1 ->3 ->0 ->2 through this table.
    tbl[0] = '{4'b0001, 0};
    tbl[1] = '{4'b0001, 0};
    tbl[2] = '{4'b1111, 1};
    tbl[3] = '{4'b1001, 3};
    tbl[4] = '{4'b1010, 1};
    tbl[5] = '{4'b0110, 2};
    tbl[6] = '{4'b0011, 0};
    tbl[7] = '{4'b1100, 2};
    tbl[8] = '{4'b1000, 3};
    tbl[9] = '{4'b1110, 1};

    for (int i = 0; i < NR; i++) s_kx_tdata[i*W_KX +: W_KX] = kx_word(i);
    s_y_tdata = '0;

    // Outputs held low during reset even with every input active.
    rst = 1'b1;
    s_kx_tvalid = '1; m_kx_tready = 1'b1; s_y_tvalid = 1'b1; m_y_tready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {s_kx_tready, m_kx_tvalid, s_y_tready, m_y_tvalid}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    s_kx_tvalid = '0; s_y_tvalid = 1'b0; m_y_tready = '0;
    @(negedge clk);
    check("post_reset_idle", {s_kx_tready, m_kx_tvalid, s_y_tready, m_y_tvalid}, '0);
    @(posedge clk);
    #1;

    // Single requester: handshake on the second edge after valid.
    s_kx_tvalid = 4'b0001; m_kx_tready = 1'b1;
    wait_kx(cyc, rdy, data);
    s_kx_tvalid = '0;
    check("single_latency", cyc + 1, 2);
    check("single_grant", rdy, 4'b0001);
    check("single_data", data, kx_word(0));
    respond(0, "single_route");

    do_reset();
    for (int v = 0; v < 10; v++) begin
      s_kx_tvalid = tbl[v].mask;
      m_kx_tready = 1'b1;
      wait_kx(cyc, rdy, data);
      s_kx_tvalid = '0;
      check("tbl_grant", rdy, onehot(tbl[v].exp_grant));
      check("tbl_data", data, kx_word(tbl[v].exp_grant));
      respond(tbl[v].exp_grant, "tbl_route");
    end

    // Fairness: two continuous requesters alternate, responses follow the same order.
    do_reset();
    s_kx_tvalid = 4'b0011; m_kx_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_kx(cyc, rdy, data);
      check("fair_grant", rdy, onehot(k % 2));
    end
    s_kx_tvalid = '0;
    for (int k = 0; k < 4; k++) respond(k % 2, "fair_route");

    // Backpressure: grant and data held while the MVM stalls.
    do_reset();
    s_kx_tvalid = 4'b0011; m_kx_tready = 1'b0; m_y_tready = '1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_tvalid", m_kx_tvalid, 1'b1);
      check("bp_tdata", m_kx_tdata, kx_word(0));
      check("bp_tready", s_kx_tready, 4'b0000);
      check("bp_no_push", s_y_tready, 1'b0);
    end
    @(posedge clk);
    #1 m_kx_tready = 1'b1;
    wait_kx(cyc, rdy, data);
    check("bp_grant_held", rdy, 4'b0001);
    wait_kx(cyc, rdy, data);
    check("bp_rr_next", rdy, 4'b0010);
    s_kx_tvalid = '0;
    respond(0, "bp_route0");
    respond(1, "bp_route1");

    // Full FIFO: four accepted, then blocked until one response pops.
    do_reset();
    s_kx_tvalid = 4'b0011; m_kx_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_kx(cyc, rdy, data);
      check("full_fill_grant", rdy, onehot(k % 2));
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("full_blocked", m_kx_tvalid, 1'b0);
    end
    @(posedge clk);
    #1 s_y_tvalid = 1'b1; m_y_tready = '1;
    @(negedge clk);
    check("full_pop_route", m_y_tvalid, 4'b0001);
    @(posedge clk);
    #1 s_y_tvalid = 1'b0;
    wait_kx(cyc, rdy, data);
    check("full_fifth_latency", cyc + 1, 2);
    check("full_fifth_grant", rdy, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("full_sixth_blocked", m_kx_tvalid, 1'b0);
    end

    // Response stall: head tag 1 not ready; requester 0 never sees tvalid.
    @(posedge clk);
    #1 s_kx_tvalid = '0; s_y_tvalid = 1'b1; m_y_tready = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_tvalid", m_y_tvalid, 4'b0010);
      check("stall_tready", s_y_tready, 1'b0);
    end
    @(posedge clk);
    #1 m_y_tready = 4'b0011;
    @(negedge clk);
    check("stall_release", {m_y_tvalid, s_y_tready}, {4'b0010, 1'b1});
    @(posedge clk);
    #1 m_y_tready = '0;
    @(negedge clk);
    check("stall_next_head", {m_y_tvalid, s_y_tready}, {4'b0001, 1'b0});

    // Reset with three tags outstanding.
    @(posedge clk);
    #1 rst = 1'b1; s_kx_tvalid = '1; m_kx_tready = 1'b1; m_y_tready = '1; s_y_tvalid = 1'b1;
    @(negedge clk);
    check("midrst_during", {s_kx_tready, m_kx_tvalid, s_y_tready, m_y_tvalid}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_after", {s_kx_tready, m_kx_tvalid, s_y_tready, m_y_tvalid}, '0);
    s_y_tvalid = 1'b0;
    wait_kx(cyc, rdy, data);
    check("midrst_first_grant", rdy, 4'b0001);
    check("midrst_latency", cyc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mvm_rr_arbiter.md
MVM_RR_ARBITER -- requirements
Module: mvm_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters sharing one axis_matvec_mul; legal range 2..8.
REQ-002 Parameter W_BUS_KX, default 224: request payload width, equal to R*C*W_K + C*W_X for R=C=8, W_X=4, W_K=3.
REQ-003 Parameter W_BUS_Y, default 80: response payload width, equal to R*(W_X+W_K+$clog2(C)).
REQ-004 Parameter DEPTH, default 4: maximum outstanding requests, i.e. tag FIFO depth; must be a power of 2.
REQ-005 Port clk, input, 1 bit: the single clock for all logic.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Ports s_axis_kx_tvalid and s_axis_kx_tready, input and output respectively, N_REQ bits each: per-requester request handshake.
REQ-008 Port s_axis_kx_tdata, input, N_REQ*W_BUS_KX bits: requester i occupies slice [i*W_BUS_KX +: W_BUS_KX].
REQ-009 Ports m_axis_kx_tvalid (output, 1 bit), m_axis_kx_tready (input, 1 bit) and m_axis_kx_tdata (output, W_BUS_KX bits): request stream to the MVM.
REQ-010 Ports s_axis_y_tvalid (input, 1 bit), s_axis_y_tready (output, 1 bit) and s_axis_y_tdata (input, W_BUS_Y bits): response stream from the MVM.
REQ-011 Ports m_axis_y_tvalid (output, N_REQ bits), m_axis_y_tready (input, N_REQ bits) and m_axis_y_tdata (output, W_BUS_Y bits, shared by all requesters): per-requester response streams.

Function
REQ-012 The request FSM SHALL have two states, IDLE and GRANT.
REQ-013 In IDLE, when any s_axis_kx_tvalid bit is 1 and the tag FIFO is not full, the FSM SHALL register grant = first valid index at or after rr_ptr, modulo N_REQ, and move to GRANT on the next edge.
REQ-014 In IDLE, no request handshake SHALL occur: m_axis_kx_tvalid = 0 and s_axis_kx_tready = 0.
REQ-015 In GRANT, the block SHALL drive m_axis_kx_tvalid = s_axis_kx_tvalid[grant] and m_axis_kx_tdata = the grant slice, and only s_axis_kx_tready[grant] SHALL equal m_axis_kx_tready.
REQ-016 In GRANT, on m_axis_kx_tvalid & m_axis_kx_tready, the block SHALL push grant into the tag FIFO, set rr_ptr = (grant+1) mod N_REQ and return to IDLE.
REQ-017 A grant SHALL be held until its handshake completes, with no re-arbitration, so that AXI-Stream data stays stable.
REQ-018 Request throughput SHALL be at most one request per 2 cycles (one IDLE bubble per request).
REQ-019 Response routing: when the tag FIFO is non-empty with head h, the block SHALL drive m_axis_y_tvalid[h] = s_axis_y_tvalid and s_axis_y_tready = m_axis_y_tready[h].
REQ-020 All other m_axis_y_tvalid bits SHALL be 0, and m_axis_y_tdata SHALL equal s_axis_y_tdata combinationally.
REQ-021 When the tag FIFO is empty, s_axis_y_tready and all m_axis_y_tvalid bits SHALL be 0.
REQ-022 The tag FIFO SHALL pop on s_axis_y_tvalid & s_axis_y_tready.
REQ-023 A push SHALL be allowed only when the FIFO is not full, gated in IDLE; a pop in the same cycle does not unblock a push.
REQ-024 Simultaneous push and pop SHALL leave the count unchanged and update both pointers.
REQ-025 Tag FIFO pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits.
REQ-026 When the FIFO is full, the FSM SHALL stay in IDLE regardless of requests until a pop occurs.
REQ-027 Responses SHALL return to requesters in request-acceptance order (the MVM is in-order).

Reset
REQ-028 On rst = 1 at a clk edge, the block SHALL set state = IDLE, grant = 0, rr_ptr = 0 and FIFO count and pointers = 0.
REQ-029 During and after reset, all outputs SHALL be 0: s_axis_kx_tready, m_axis_kx_tvalid, s_axis_y_tready and m_axis_y_tvalid.
REQ-030 A reset mid-operation SHALL discard all outstanding tags; the MVM is reset by the same rst.

Structure
REQ-031 Package mvm_pkg SHALL hold R, C, W_X, W_K, the derived W_Y, W_BUS_KX and W_BUS_Y, and the FSM state enum {IDLE, GRANT}.
REQ-032 The tag FIFO SHALL be a sub-module mvm_tag_fifo, parameterised by DEPTH and W_TAG = $clog2(N_REQ), with push/pop/full/empty/head ports.

Verification
REQ-033 Single requester: N_REQ=2, req0 valid with kx=A, MVM ready -> handshake in cycle 2 after valid; y returned routed only to m_axis_y_tvalid[0].
REQ-034 Fairness: both requesters valid continuously, rr_ptr=0 -> grant order 0,1,0,1 over 4 requests; responses alternate 0,1,0,1.
REQ-035 Backpressure: MVM m_axis_kx_tready low for 5 cycles while granted -> grant and tdata stable, no push, no rr_ptr change.
REQ-036 Full FIFO: DEPTH=4, responses withheld, 6 requests offered -> exactly 4 accepted; the 5th is accepted only in the cycle after the first response pop.
REQ-037 Response stall: m_axis_y_tready[h]=0 -> s_axis_y_tready=0, FIFO head unchanged, and the other requester never sees tvalid.
REQ-038 Reset mid-operation: rst asserted with 3 tags outstanding -> next cycle all outputs 0, count 0, and the first post-reset grant goes to requester 0.
